dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU / debug-loader) arbiter in front of a single
// data-memory port. Each transfer runs IDLE -> ACCESS (WAIT+1 cycles) -> RESP.
// The memory is written on the last ACCESS cycle, and read data is captured
// on that same edge.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests. The default build gives the CPU fixed priority.
module dmem_arbiter #(
   parameter int unsigned WAIT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [1:0]  cpu_size,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   input  logic [1:0]  dbg_size,
   output logic        dbg_ack,
   output logic [31:0] dbg_rdata,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_lwhb,
   output logic [1:0]  mem_swhb,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic       GNT_CPU = 1'b0;
   localparam logic       GNT_DBG = 1'b1;
   localparam logic [3:0] WAIT_L  = 4'(WAIT);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        grant_q, grant_d;
   logic        last_grant_q, last_grant_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic [31:0] dbg_rdata_q, dbg_rdata_d;
   logic        pick_dbg;
   logic        in_access;
   logic        in_resp;

   // Winner selection among the current requests (only consumed in IDLE)
   always_comb begin
      pick_dbg = dbg_req;
      if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_RR_EN
         pick_dbg = (last_grant_q == GNT_CPU);
`else
         pick_dbg = GNT_CPU;
`endif
      end
   end

   // Next-state logic: arbitration, wait countdown, read-data capture
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      size_d       = size_q;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      case (state_q)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               state_d      = ACCESS;
               cnt_d        = WAIT_L;
               grant_d      = pick_dbg;
               last_grant_d = pick_dbg;
               if (pick_dbg == GNT_DBG) begin
                  we_d    = dbg_we;
                  addr_d  = dbg_addr;
                  wdata_d = dbg_wdata;
                  size_d  = dbg_size;
               end else begin
                  we_d    = cpu_we;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
                  size_d  = cpu_size;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               if (!we_q) begin
                  if (grant_q == GNT_DBG) dbg_rdata_d = mem_rdata;
                  else                    cpu_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transfer in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         grant_q      <= GNT_CPU;
         last_grant_q <= GNT_DBG;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         size_q       <= 2'd0;
         cpu_rdata_q  <= 32'd0;
         dbg_rdata_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         size_q       <= size_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   // Output decode: memory fields only driven during ACCESS, acks only in RESP
   always_comb begin
      in_access = (state_q == ACCESS);
      in_resp   = (state_q == RESP);
      mem_write = in_access && (cnt_q == 4'd0) && we_q;
      mem_addr  = in_access ? addr_q  : 32'd0;
      mem_wdata = in_access ? wdata_q : 32'd0;
      mem_lwhb  = in_access ? size_q  : 2'd0;
      mem_swhb  = in_access ? size_q  : 2'd0;
      cpu_ack   = in_resp && (grant_q == GNT_CPU);
      dbg_ack   = in_resp && (grant_q == GNT_DBG);
      cpu_stall = cpu_req && !cpu_ack;
      cpu_rdata = cpu_rdata_q;
      dbg_rdata = dbg_rdata_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: transaction-schedule reference model plus
// randomized requesters, with directed scenarios for latency, writes,
// arbitration order, reset abort and late-arriving requests.
module tb_dmem_arbiter;

   localparam int WAIT = 1;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic        a_req[2];
   logic        a_we[2];
   logic [31:0] a_addr[2];
   logic [31:0] a_wdata[2];
   logic [1:0]  a_size[2];
   bit          a_rnd[2];
   bit          a_rep[2];

   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic [1:0]  cpu_size, dbg_size;
   logic        cpu_ack, cpu_stall, dbg_ack, mem_write;
   logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_lwhb, mem_swhb;

   assign cpu_req   = a_req[0];
   assign cpu_we    = a_we[0];
   assign cpu_addr  = a_addr[0];
   assign cpu_wdata = a_wdata[0];
   assign cpu_size  = a_size[0];
   assign dbg_req   = a_req[1];
   assign dbg_we    = a_we[1];
   assign dbg_addr  = a_addr[1];
   assign dbg_wdata = a_wdata[1];
   assign dbg_size  = a_size[1];

   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A1234);
   endfunction

   assign mem_rdata = rom(mem_addr);

   dmem_arbiter #(.WAIT(WAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_ack(cpu_ack),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_size(dbg_size), .dbg_ack(dbg_ack),
      .dbg_rdata(dbg_rdata),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_lwhb(mem_lwhb), .mem_swhb(mem_swhb), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: one transfer occupies the port for WAIT+3 edges from
   // its sampling edge; everything is derived from offsets within that window.
   int          cyc = 0;
   int          free_at = 0;
   int          t_s = 0;
   bit          t_act = 1'b0;
   bit          t_win = 1'b0;
   bit          t_we = 1'b0;
   logic [31:0] t_addr = '0, t_wdata = '0;
   logic [1:0]  t_size = '0;
   bit          m_last = 1'b1;
   logic [31:0] rd_exp[2];
   bit          e_ack[2];
   bit          o_ack[2];
   int          ack_log[$];

   task automatic model_sample();
      if (cyc >= free_at) begin
         t_act = 1'b0;
         if (a_req[0] || a_req[1]) begin
            if (a_req[0] && a_req[1]) t_win = RR ? !m_last : 1'b0;
            else                      t_win = a_req[1];
            t_we    = a_we[t_win];
            t_addr  = a_addr[t_win];
            t_wdata = a_wdata[t_win];
            t_size  = a_size[t_win];
            t_act   = 1'b1;
            t_s     = cyc;
            m_last  = t_win;
            free_at = cyc + WAIT + 3;
         end else begin
            free_at = cyc + 1;
         end
      end
   endtask

   task automatic check_outputs();
      int k;
      bit acc, wr, resp;
      k    = cyc - t_s;
      acc  = t_act && (k <= WAIT);
      wr   = acc && (k == WAIT) && t_we;
      resp = t_act && (k == WAIT + 1);
      e_ack[0] = resp && !t_win;
      e_ack[1] = resp && t_win;
      if (resp && !t_we) rd_exp[t_win] = rom(t_addr);
      check("cpu_ack",   32'(cpu_ack),   32'(e_ack[0]));
      check("dbg_ack",   32'(dbg_ack),   32'(e_ack[1]));
      check("mem_write", 32'(mem_write), 32'(wr));
      check("mem_addr",  mem_addr,       acc ? t_addr  : 32'd0);
      check("mem_wdata", mem_wdata,      acc ? t_wdata : 32'd0);
      check("mem_lwhb",  32'(mem_lwhb),  acc ? 32'(t_size) : 32'd0);
      check("mem_swhb",  32'(mem_swhb),  acc ? 32'(t_size) : 32'd0);
      check("cpu_stall", 32'(cpu_stall), 32'(a_req[0] && !e_ack[0]));
      check("cpu_rdata", cpu_rdata,      rd_exp[0]);
      check("dbg_rdata", dbg_rdata,      rd_exp[1]);
   endtask

   task automatic new_req(input int p);
      a_we[p]    = 1'($urandom_range(0, 1));
      a_addr[p]  = $urandom;
      a_wdata[p] = $urandom;
      a_size[p]  = 2'($urandom_range(0, 2));
      a_req[p]   = 1'b1;
   endtask

   task automatic issue(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size);
      a_we[p]    = we;
      a_addr[p]  = addr;
      a_wdata[p] = wdata;
      a_size[p]  = size;
      a_req[p]   = 1'b1;
   endtask

   task automatic agent_update();
      for (int p = 0; p < 2; p++) begin
         if (a_req[p] && e_ack[p]) begin
            if (a_rep[p])                             a_req[p] = 1'b1;
            else if (a_rnd[p] && $urandom_range(0, 1) == 1) new_req(p);
            else                                      a_req[p] = 1'b0;
         end else if (!a_req[p] && a_rnd[p] && $urandom_range(0, 3) == 0) begin
            new_req(p);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_sample();
      @(negedge clk);
      check_outputs();
      o_ack[0] = cpu_ack;
      o_ack[1] = dbg_ack;
      if (cpu_ack) ack_log.push_back(0);
      if (dbg_ack) ack_log.push_back(1);
      agent_update();
   endtask

   initial begin
      int n, stall_cnt, wr_cnt, wr_step, bad;
      logic [31:0] wr_addr, wr_data;
      logic [1:0]  wr_swhb;
      int exp_order[4];
      int obs;

      for (int p = 0; p < 2; p++) begin
         a_req[p] = 1'b0; a_we[p] = 1'b0; a_addr[p] = '0; a_wdata[p] = '0;
         a_size[p] = '0; a_rnd[p] = 1'b0; a_rep[p] = 1'b0;
         rd_exp[p] = '0; e_ack[p] = 1'b0; o_ack[p] = 1'b0;
      end

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs();
      reset = 1'b0;

      // CPU read of 0x10
      step();
      issue(0, 1'b0, 32'h10, 32'h0, 2'b10);
      #1 stall_cnt = int'(cpu_stall);
      n = 0;
      while (n < 40) begin
         step(); n++;
         if (cpu_stall) stall_cnt++;
         if (o_ack[0]) break;
      end
      check("cpu_rd_latency", 32'(n), 32'(WAIT + 2));
      check("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
      check("cpu_stall_cycles", 32'(stall_cnt), 32'(WAIT + 2));

      // debug word write
      step();
      issue(1, 1'b1, 32'h20, 32'h12345678, 2'b10);
      wr_cnt = 0; wr_step = 0; wr_addr = '0; wr_data = '0; wr_swhb = '0; n = 0;
      while (n < 40) begin
         step(); n++;
         if (mem_write) begin
            wr_cnt++; wr_step = n; wr_addr = mem_addr; wr_data = mem_wdata; wr_swhb = mem_swhb;
         end
         if (o_ack[1]) break;
      end
      check("dbg_wr_pulses", 32'(wr_cnt), 32'd1);
      check("dbg_wr_cycle", 32'(wr_step), 32'(WAIT + 1));
      check("dbg_wr_ack_latency", 32'(n), 32'(WAIT + 2));
      check("dbg_wr_addr", wr_addr, 32'h20);
      check("dbg_wr_data", wr_data, 32'h12345678);
      check("dbg_wr_swhb", 32'(wr_swhb), 32'd2);

      // both requesters continuously busy
      step();
      ack_log.delete();
      a_rep[0] = 1'b1; a_rep[1] = 1'b1;
      issue(0, 1'b0, 32'h40, 32'h0, 2'b10);
      issue(1, 1'b0, 32'h80, 32'h0, 2'b01);
      if (RR) exp_order = '{0, 1, 0, 1};
      else    exp_order = '{0, 0, 0, 0};
      n = 0;
      while (ack_log.size() < 4 && n < 200) begin step(); n++; end
      for (int i = 0; i < 4; i++) begin
         obs = (i < ack_log.size()) ? ack_log[i] : 99;
         check($sformatf("grant_order[%0d]", i), 32'(obs), 32'(exp_order[i]));
      end
      a_rep[0] = 1'b0; a_rep[1] = 1'b0;
      n = 0;
      while ((a_req[0] || a_req[1]) && n < 200) begin step(); n++; end

      // reset during the first ACCESS cycle of a debug write
      step();
      issue(1, 1'b1, 32'h30, 32'hCAFEF00D, 2'b10);
      step();
      reset = 1'b1;
      #1;
      t_act = 1'b0; m_last = 1'b1; rd_exp[0] = '0; rd_exp[1] = '0;
      a_req[1] = 1'b0;
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      reset = 1'b0;
      free_at = cyc;
      bad = 0;
      for (int i = 0; i < WAIT + 3; i++) begin
         step();
         if (mem_write || dbg_ack || cpu_ack) bad++;
      end
      check("rst_abort_quiet", 32'(bad), 32'd0);
      issue(0, 1'b0, 32'h44, 32'h0, 2'b00);
      n = 0;
      while (n < 40) begin step(); n++; if (o_ack[0]) break; end
      check("post_rst_latency", 32'(n), 32'(WAIT + 2));
      check("post_rst_rdata", cpu_rdata, rom(32'h44));

      // debug request arriving during a CPU ACCESS
      step();
      ack_log.delete();
      issue(0, 1'b0, 32'h54, 32'h0, 2'b10);
      step();
      issue(1, 1'b0, 32'h58, 32'h0, 2'b01);
      n = 0;
      while (n < 60) begin step(); n++; if (o_ack[1]) break; end
      check("late_dbg_latency", 32'(n), 32'(2 * WAIT + 4));
      for (int i = 0; i < 2; i++) begin
         obs = (i < ack_log.size()) ? ack_log[i] : 99;
         check($sformatf("late_order[%0d]", i), 32'(obs), 32'(i));
      end
      check("late_dbg_rdata", dbg_rdata, rom(32'h58));

      // randomized traffic
      a_rnd[0] = 1'b1; a_rnd[1] = 1'b1;
      repeat (1500) step();
      a_rnd[0] = 1'b0; a_rnd[1] = 1'b0;
      n = 0;
      while ((a_req[0] || a_req[1]) && n < 200) begin step(); n++; end
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
